// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the serial pattern detector: WIDTH-bit words in, one bit per BIT_PERIOD clocks out.
// Optional even-parity trailer bit when SERIAL_FEEDER_PARITY_EN is defined.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int BIT_PERIOD = 1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef SERIAL_FEEDER_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic               par_q, par_d;
`endif

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tick_d       = tick_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d      = SHIFT;
          shift_d      = data_in;
          bit_cnt_d    = {CNT_W{1'b0}};
          tick_d       = {TICK_W{1'b0}};
          dout_d       = head_bit(data_in);
          dout_valid_d = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
          par_d        = even_parity(data_in);
`endif
        end else begin
          dout_d       = IDLE_LEVEL;
          dout_valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick_q == TICK_LAST) begin
          tick_d = {TICK_W{1'b0}};
          if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_FEEDER_PARITY_EN
            state_d = PARITY;
            dout_d  = par_q;
`else
            state_d      = IDLE;
            dout_d       = IDLE_LEVEL;
            dout_valid_d = 1'b0;
`endif
          end else begin
            shift_d   = advance(shift_q);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            dout_d    = head_bit(advance(shift_q));
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      PARITY: begin
        if (tick_q == TICK_LAST) begin
          state_d      = IDLE;
          tick_d       = {TICK_W{1'b0}};
          dout_d       = IDLE_LEVEL;
          dout_valid_d = 1'b0;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`endif
      default: begin
        state_d      = IDLE;
        dout_d       = IDLE_LEVEL;
        dout_valid_d = 1'b0;
      end
    endcase

    // done is registered, so it is raised one edge early for the final frame cycle
`ifdef SERIAL_FEEDER_PARITY_EN
    done_d = (state_d == PARITY) && (tick_d == TICK_LAST);
`else
    done_d = (state_d == SHIFT) && (bit_cnt_d == BIT_LAST) && (tick_d == TICK_LAST);
`endif
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= {WIDTH{1'b0}};
      bit_cnt_q    <= {CNT_W{1'b0}};
      tick_q       <= {TICK_W{1'b0}};
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tick_q       <= tick_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign data_ready = (state_q == IDLE) && !rst;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two configurations checked cycle by cycle against a frame-queue reference model.
// Honours SERIAL_FEEDER_PARITY_EN the same way the design does.
module tb_serial_bit_feeder;

  localparam int        WIDTH  = 8;
  localparam int        BP0    = 1;
  localparam int        BP1    = 3;
  localparam bit [1:0]  MSB_F  = 2'b01;   // unit 0 MSB first, unit 1 LSB first
  localparam bit [1:0]  IDLE_L = 2'b01;   // unit 0 idles high, unit 1 idles low

  logic             clk = 1'b0;
  logic [1:0]       rst_i;
  logic [1:0]       valid_i;
  logic [WIDTH-1:0] data0, data1;
  logic [1:0]       ready_o, dout_o, dvalid_o, busy_o, done_o;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // expected per-cycle entry: {dout, dout_valid, done}
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .BIT_PERIOD(BP0), .IDLE_LEVEL(1'b1)) dut0 (
    .clk(clk), .rst(rst_i[0]), .data_in(data0), .data_valid(valid_i[0]),
    .data_ready(ready_o[0]), .dout(dout_o[0]), .dout_valid(dvalid_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .BIT_PERIOD(BP1), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .rst(rst_i[1]), .data_in(data1), .data_valid(valid_i[1]),
    .data_ready(ready_o[1]), .dout(dout_o[1]), .dout_valid(dvalid_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic int bp_of(input int u);
    return (u == 1) ? BP1 : BP0;
  endfunction

  // Builds the whole expected frame for one accepted word.
  task automatic push_frame(input int u, input logic [WIDTH-1:0] w);
    logic b;
    for (int i = 0; i < WIDTH; i++) begin
      b = MSB_F[u] ? w[WIDTH-1-i] : w[i];
      for (int t = 0; t < bp_of(u); t++) exp_q.push_back({b, 1'b1, 1'b0});
    end
`ifdef SERIAL_FEEDER_PARITY_EN
    for (int t = 0; t < bp_of(u); t++) exp_q.push_back({^w, 1'b1, 1'b0});
`endif
    exp_q[exp_q.size()-1][0] = 1'b1;
  endtask

  // One clock cycle on unit u: drive inputs, compare outputs, advance the model.
  task automatic tick(input int u, input logic r, input logic v, input logic [WIDTH-1:0] d);
    logic [2:0] cur;
    logic       idle;
    rst_i[u]   = r;
    valid_i[u] = v;
    if (u == 0) data0 = d; else data1 = d;
    #1;
    if (exp_q.size() > 0) begin
      cur  = exp_q.pop_front();
      idle = 1'b0;
    end else begin
      cur  = {IDLE_L[u], 2'b00};
      idle = 1'b1;
    end
    check_eq($sformatf("u%0d_dout", u),       dout_o[u],   cur[2]);
    check_eq($sformatf("u%0d_dout_valid", u), dvalid_o[u], cur[1]);
    check_eq($sformatf("u%0d_done", u),       done_o[u],   cur[0]);
    check_eq($sformatf("u%0d_busy", u),       busy_o[u],   !idle);
    check_eq($sformatf("u%0d_data_ready", u), ready_o[u],  idle && !r);
    if (r) exp_q.delete();
    else if (v && idle) push_frame(u, d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int u, input int n);
    for (int i = 0; i < n; i++) tick(u, 1'b0, 1'b0, WIDTH'($urandom));
  endtask

  task automatic run_unit(input int u);
    int flen;
    flen = WIDTH * bp_of(u);
`ifdef SERIAL_FEEDER_PARITY_EN
    flen = flen + bp_of(u);
`endif
    exp_q.delete();
    tick(u, 1'b1, 1'b0, 8'h00);
    tick(u, 1'b1, 1'b1, 8'h5A);
    // single word 0x96
    tick(u, 1'b0, 1'b1, 8'h96);
    idle_cycles(u, flen + 2);
    // 0xA5, checks per-bit hold
    tick(u, 1'b0, 1'b1, 8'hA5);
    idle_cycles(u, flen + 1);
    // back-to-back with valid held high
    tick(u, 1'b0, 1'b1, 8'hF0);
    for (int i = 0; i < flen + 1; i++) tick(u, 1'b0, 1'b1, 8'h0F);
    idle_cycles(u, flen + 1);
    // reset in the 4th bit of 0xFF, then a normal word
    tick(u, 1'b0, 1'b1, 8'hFF);
    idle_cycles(u, 3 * bp_of(u));
    tick(u, 1'b1, 1'b0, 8'h00);
    idle_cycles(u, 2);
    tick(u, 1'b0, 1'b1, 8'h07);
    idle_cycles(u, flen + 1);
    // randomized traffic, including data changing while busy and sparse resets
    for (int i = 0; i < 500; i++)
      tick(u, ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7), WIDTH'($urandom));
    idle_cycles(u, flen + 1);
  endtask

  initial begin
    rst_i   = 2'b11;
    valid_i = 2'b00;
    data0   = '0;
    data1   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 2'b10;
    run_unit(0);
    rst_i = 2'b01;
    @(negedge clk);
    run_unit(1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
